// File: rtl/regfile_pkg.sv
// Shared defaults and packed-bus slicing helper for the multi-port register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Low bit of element idx inside a packed bus of width-bit elements.
  function automatic int lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port: zero-register override, write-port bypass (highest index wins), else storage.
// Purely combinational; also masks the busy flag when a same-cycle write-back hits.
module regfile_fwd_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0]        i_rd_addr,
  input  logic [DATA_W-1:0]        i_store_data,
  input  logic                     i_store_busy,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_rd_busy
);

  logic              w_hit;
  logic              w_zero;
  logic [DATA_W-1:0] w_fwd;

  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    // Ascending scan so the last (highest-index) matching port overrides.
    for (int j = 0; j < NUM_WR; j++) begin
      if (i_wr_en[j] && (i_wr_addr[lsb(j, ADDR_W) +: ADDR_W] == i_rd_addr)) begin
        w_hit = 1'b1;
        w_fwd = i_wr_data[lsb(j, DATA_W) +: DATA_W];
      end
    end
    w_zero    = (ZERO_REG != 0) && (i_rd_addr == '0);
    o_rd_data = w_zero ? '0 : (w_hit ? w_fwd : i_store_data);
    o_rd_busy = !w_zero && i_store_busy && !w_hit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational reads with bypass, NUM_WR rising-edge writes,
// and a per-register pending-write scoreboard (reservation beats a same-cycle write-back).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;

  logic [ADDR_W-1:0] w_wr_addr [NUM_WR];
  logic [DATA_W-1:0] w_wr_data [NUM_WR];

  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign w_wr_addr[j] = wr_addr[lsb(j, ADDR_W) +: ADDR_W];
    assign w_wr_data[j] = wr_data[lsb(j, DATA_W) +: DATA_W];
  end

  // Later loop iterations override earlier ones, giving the highest write port priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && !((ZERO_REG != 0) && (w_wr_addr[j] == '0))) begin
          r_regs[w_wr_addr[j]] <= w_wr_data[j];
        end
      end
    end
  end

  // Write-backs clear first, then the reservation sets: the newer producer stays outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j]) begin
          r_busy[w_wr_addr[j]] <= 1'b0;
        end
      end
      if (rsv_en) begin
        r_busy[rsv_addr] <= 1'b1;
      end
      if (ZERO_REG != 0) begin
        r_busy[0] <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = rd_addr[lsb(i, ADDR_W) +: ADDR_W];

    regfile_fwd_mux #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_fwd_mux (
      .i_rd_addr   (w_addr),
      .i_store_data(r_regs[w_addr]),
      .i_store_busy(r_busy[w_addr]),
      .i_wr_en     (wr_en),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .o_rd_data   (rd_data[lsb(i, DATA_W) +: DATA_W]),
      .o_rd_busy   (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Cycle-by-cycle vectors for regfile_mp: each record drives one cycle and queues the expected reads.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [1:0]  wen;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [4:0]  ra0, ra1;
    logic [31:0] ed0, ed1;
    logic        eb0, eb1;
  } vec_t;

  typedef struct packed {
    logic [31:0] d0, d1;
    logic        b0, b1;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic r, input logic rv, input logic [4:0] ra,
                              input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [4:0] q0, input logic [4:0] q1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic b0, input logic b1);
    vec_t v;
    v.rst = r;  v.rsv_en = rv; v.rsv_addr = ra; v.wen = we;
    v.wa0 = a0; v.wa1 = a1; v.wd0 = d0; v.wd1 = d1;
    v.ra0 = q0; v.ra1 = q1; v.ed0 = e0; v.ed1 = e1; v.eb0 = b0; v.eb1 = b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Called just after a rising edge: drive one cycle, queue expectation, compare on the falling edge.
  task automatic apply(input string tag, input vec_t v);
    exp_t e;
    rst      = v.rst;
    rsv_en   = v.rsv_en;
    rsv_addr = v.rsv_addr;
    wr_en    = v.wen;
    wr_addr  = {v.wa1, v.wa0};
    wr_data  = {v.wd1, v.wd0};
    rd_addr  = {v.ra1, v.ra0};
    sb_q.push_back('{d0: v.ed0, d1: v.ed1, b0: v.eb0, b1: v.eb1});
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.queue: got empty scoreboard, expected one entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, ".rd_data0"}, rd_data[31:0],  e.d0);
      check({tag, ".rd_data1"}, rd_data[63:32], e.d1);
      check({tag, ".rd_busy0"}, {31'd0, rd_busy[0]}, {31'd0, e.b0});
      check({tag, ".rd_busy1"}, {31'd0, rd_busy[1]}, {31'd0, e.b1});
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //              rst rsv raddr wen  wa0 wa1 wd0           wd1           ra0 ra1 ed0           ed1           b0 b1
    vecs[0]  = mk(1, 0, 0,  2'b00, 0,  0,  0,            0,            0,  1,  0,            0,            0, 0);
    vecs[1]  = mk(0, 0, 0,  2'b01, 5,  0,  32'hDEADBEEF, 0,            5,  6,  32'hDEADBEEF, 0,            0, 0);
    vecs[2]  = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            5,  7,  32'hDEADBEEF, 0,            0, 0);
    vecs[3]  = mk(0, 0, 0,  2'b11, 7,  7,  32'h11,       32'h22,       7,  5,  32'h22,       32'hDEADBEEF, 0, 0);
    vecs[4]  = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            7,  7,  32'h22,       32'h22,       0, 0);
    vecs[5]  = mk(0, 1, 0,  2'b01, 0,  0,  32'hFFFFFFFF, 0,            0,  0,  0,            0,            0, 0);
    vecs[6]  = mk(0, 1, 3,  2'b00, 0,  0,  0,            0,            0,  3,  0,            0,            0, 0);
    vecs[7]  = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            3,  3,  0,            0,            1, 1);
    vecs[8]  = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            3,  4,  0,            0,            1, 0);
    vecs[9]  = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            4,  3,  0,            0,            0, 1);
    vecs[10] = mk(0, 0, 0,  2'b10, 0,  3,  0,            32'h0000ABCD, 3,  3,  32'h0000ABCD, 32'h0000ABCD, 0, 0);
    vecs[11] = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            3,  5,  32'h0000ABCD, 32'hDEADBEEF, 0, 0);
    vecs[12] = mk(0, 1, 3,  2'b01, 3,  0,  32'h1234,     0,            3,  7,  32'h1234,     32'h22,       0, 0);
    vecs[13] = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            3,  3,  32'h1234,     32'h1234,     1, 1);
    vecs[14] = mk(0, 0, 0,  2'b11, 3,  3,  32'h5678,     32'h9999,     3,  1,  32'h9999,     0,            0, 0);
    vecs[15] = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            3,  3,  32'h9999,     32'h9999,     0, 0);
    vecs[16] = mk(1, 0, 0,  2'b01, 12, 0,  32'hCAFE,     0,            12, 5,  32'hCAFE,     32'hDEADBEEF, 0, 0);
    vecs[17] = mk(0, 0, 0,  2'b00, 0,  0,  0,            0,            12, 5,  0,            0,            0, 0);

    rst = 1'b1; rsv_en = 1'b0; rsv_addr = '0;
    wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    @(posedge clk);
    #1;

    // Every address reads zero and idle straight after a one-cycle reset.
    for (int a = 0; a < 32; a += 2) begin
      apply($sformatf("post_reset_r%0d", a),
            mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 5'(a), 5'(a + 1), 0, 0, 0, 0));
    end

    for (int i = 0; i < 18; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset mid-operation drops the reservation and the reset-cycle write.
    apply("midrst_a", mk(0, 1, 9, 2'b01, 10, 0, 32'h55, 0, 9, 10, 0, 32'h55, 0, 0));
    apply("midrst_b", mk(1, 0, 0, 2'b01, 10, 0, 32'h66, 0, 9, 10, 0, 32'h66, 1, 0));
    apply("midrst_c", mk(0, 0, 0, 2'b00, 0,  0, 0,      0, 9, 10, 0, 0,      0, 0));

    // Reservation on a high port-1 address then a port-0 write-back clears it.
    apply("sb_hi_a", mk(0, 1, 31, 2'b00, 0, 0, 0, 0, 31, 30, 0, 0, 0, 0));
    apply("sb_hi_b", mk(0, 0, 0, 2'b01, 31, 0, 32'hA5A5A5A5, 0, 30, 31, 0, 32'hA5A5A5A5, 0, 0));
    apply("sb_hi_c", mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 31, 31, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
